// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a producer and the buffered UART transmitter.
interface uart_tx_buffered_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back-to-back
// while the FIFO holds data, and the serial line comes straight from a flop.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_buffered_if.slave in_if,
    output logic              transmitData,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            ready_q, ready_d;
    logic            tx_q, tx_d;
    logic            push, pop, bit_done, fifo_empty;
    logic [7:0]      mem [FIFO_DEPTH];

    assign push       = in_if.tx_valid && ready_q;
    assign fifo_empty = (count_q == '0);
    assign bit_done   = (cnt_q == CNT_MAX);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when a byte is waiting.
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL_CNT);
    end

    // The line lags the state by one cycle, which gives the two-edge start latency.
    always_comb begin
        unique case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
        end
    end

    // NOTE: storage is not reset; the zeroed count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_if.tx_data;
    end

    assign in_if.tx_ready = ready_q;
    assign transmitData   = tx_q;
    assign busy           = (state_q != IDLE) || !fifo_empty;
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries in the input buffer; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tx_data  input  8  byte to send, sampled when tx_valid and tx_ready are both high.
REQ-006 tx_valid  input  1  producer has a byte on tx_data.
REQ-007 tx_ready  output  1  buffer can accept a byte this cycle.
REQ-008 transmitData  output  1  serial line: 8N1, idle high, LSB first.
REQ-009 busy  output  1  frame on the line or buffer non-empty.

Function
REQ-010 The block SHALL accept a byte on any rising edge where tx_valid=1 and tx_ready=1, and SHALL ignore tx_data otherwise.
REQ-011 tx_ready SHALL equal NOT full, where full means FIFO_DEPTH entries are stored; it SHALL not depend combinationally on tx_valid.
REQ-012 The FIFO SHALL be first-in first-out; read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy count SHALL be 0..FIFO_DEPTH.
REQ-013 A push and a pop in the same cycle SHALL leave the count unchanged and SHALL lose no data, including when count=1.
REQ-014 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE: transmitData=1; when the FIFO is non-empty, pop the head into the shift register and go to START on the next edge.
REQ-016 START: transmitData=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-017 DATA: drive shift bit [index] for exactly CLKS_PER_BIT cycles per bit, index 0..7; after index 7 go to STOP.
REQ-018 STOP: transmitData=1 for exactly CLKS_PER_BIT cycles. Then go to START with a new pop if the FIFO is non-empty (no idle gap between frames), else go to IDLE.
REQ-019 One frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-020 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL restart at 0 on every state change.
REQ-021 transmitData SHALL be driven directly from a flop, with no combinational path from any input.
REQ-022 Latency: a byte accepted into an empty FIFO while in IDLE SHALL produce the start bit on transmitData at the second rising edge after acceptance.
REQ-023 busy SHALL be 1 whenever the state is not IDLE or the count is nonzero; otherwise 0.
REQ-024 A byte in the shift register SHALL not be affected by pushes arriving during its frame.

Reset
REQ-025 While rst=1, the block SHALL force and hold: transmitData=1, tx_ready=0, busy=0, state=IDLE, count=0, pointers=0, all counters=0.
REQ-026 Assertion of rst mid-frame SHALL immediately return transmitData to 1, abandon the frame and discard all buffered bytes.
REQ-027 tx_ready SHALL rise on the first rising edge after rst deasserts; no byte SHALL be accepted while rst=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Push 0xA5 once from idle -> start bit 2 edges later; line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total; then busy=0.
REQ-029 Push 0x00, 0xFF and 0x3C back-to-back -> three contiguous frames, each stop bit followed directly by the next start bit; 120 cycles total; byte order preserved.
REQ-030 Hold tx_valid=1 with 6 distinct bytes -> tx_ready drops when full; all 6 bytes appear on the line in order, with none dropped or duplicated.
REQ-031 With count=1 and the FSM popping, push in the same cycle -> count stays 1 and the pushed byte becomes the next frame.
REQ-032 Assert rst during DATA bit 3 of 0x81 with 2 bytes queued -> transmitData=1 immediately; busy=0; after release the line stays idle-high with no residual frame.
REQ-033 Vary CLKS_PER_BIT to 2 and 7 with byte 0x55 -> every bit lasts exactly CLKS_PER_BIT cycles, measured edge to edge.
